rs_dsp_multacc_pipe: RTL and testbench

Parametrised successor to the fixed 20x18 DSP multiply-add primitive wrapper. Pipelined signed/unsigned multiply-accumulate with configurable operand and accumulator widths and an optional input register stage. Output post-processing provides per-transaction shift-right, round and saturate, plus an overflow flag. Uses a valid handshake and sits between the datapath and the DSP38 inference layer as the generic MAC building block.

---
 rtl/rs_dsp_pkg.sv | 27 ++
 rtl/rs_dsp_round_sat.sv | 58 +++++
 rtl/rs_dsp_multacc_pipe.sv | 189 ++++++++++++++++++
 tb/tb_rs_dsp_multacc_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rs_dsp_pkg.sv
// Shared types and elaboration helpers for the rs_dsp multiply-accumulate block.
package rs_dsp_pkg;

    typedef enum logic [1:0] {
        FB_MULT     = 2'd0,
        FB_MAC      = 2'd1,
        FB_READ_ACC = 2'd2
    } fb_mode_e;

    localparam int SHIFT_W = 6;

    typedef struct packed {
        logic               unsigned_a;
        logic               unsigned_b;
        logic [1:0]         feedback;
        logic               load_acc;
        logic               subtract;
        logic [SHIFT_W-1:0] shift_right;
        logic               round;
        logic               saturate_enable;
    } ctrl_t;

    function automatic bit widths_ok(input int a_w, input int b_w, input int z_w, input int acc_w);
        return (acc_w >= a_w + b_w + 2) && (acc_w >= z_w) && (z_w > 0);
    endfunction

endpackage

// File: rtl/rs_dsp_round_sat.sv
// Combinational output stage: round-half-up, arithmetic shift, range check and optional clamp.
module rs_dsp_round_sat
    import rs_dsp_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int Z_W   = 38
) (
    input  logic [ACC_W-1:0]   i_value,
    input  logic [SHIFT_W-1:0] i_shift,
    input  logic               i_round,
    input  logic               i_saturate,
    input  logic               i_unsigned,
    output logic [Z_W-1:0]     o_z,
    output logic               o_overflow
);

    // One extra bit so the rounding bias can never wrap the accumulator value.
    localparam int RW = ACC_W + 1;
    localparam logic signed [RW-1:0] ONE   = RW'(1);
    localparam logic signed [RW-1:0] U_MAX = (ONE <<< Z_W) - ONE;
    localparam logic signed [RW-1:0] S_MAX = (ONE <<< (Z_W - 1)) - ONE;
    localparam logic signed [RW-1:0] S_MIN = -(ONE <<< (Z_W - 1));

    logic signed [RW-1:0] w_ext;
    logic signed [RW-1:0] w_bias;
    logic signed [RW-1:0] w_sum;
    logic signed [RW-1:0] w_shifted;
    logic signed [RW-1:0] w_hi;
    logic signed [RW-1:0] w_lo;
    logic                 w_above;
    logic                 w_below;

    always_comb begin
        w_ext  = RW'($signed(i_value));
        w_bias = '0;
        if (i_round && (i_shift != '0) && (int'(i_shift) < ACC_W)) begin
            w_bias = ONE <<< (i_shift - 1'b1);
        end
        w_sum = w_ext + w_bias;
        if (int'(i_shift) >= ACC_W) begin
            w_shifted = {RW{w_ext[RW-1]}};
        end else begin
            w_shifted = w_sum >>> i_shift;
        end
        w_hi       = i_unsigned ? U_MAX : S_MAX;
        w_lo       = i_unsigned ? '0 : S_MIN;
        w_above    = w_shifted > w_hi;
        w_below    = w_shifted < w_lo;
        o_overflow = w_above | w_below;
        o_z        = w_shifted[Z_W-1:0];
        if (i_saturate && w_above) begin
            o_z = w_hi[Z_W-1:0];
        end else if (i_saturate && w_below) begin
            o_z = w_lo[Z_W-1:0];
        end
    end

endmodule

// File: rtl/rs_dsp_multacc_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with shift/round/saturate output.
// Define RS_DSP_MULTACC_STALL_EN to add out_ready backpressure that freezes the whole pipe.
module rs_dsp_multacc_pipe
    import rs_dsp_pkg::*;
#(
    parameter int A_W    = 20,
    parameter int B_W    = 18,
    parameter int Z_W    = 38,
    parameter int ACC_W  = 48,
    parameter int IN_REG = 1
) (
    input  logic               clk,
    input  logic               lreset,
    input  logic               in_valid,
    output logic               in_ready,
`ifdef RS_DSP_MULTACC_STALL_EN
    input  logic               out_ready,
`endif
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    input  logic               unsigned_a,
    input  logic               unsigned_b,
    input  logic [1:0]         feedback,
    input  logic               load_acc,
    input  logic               subtract,
    input  logic [SHIFT_W-1:0] shift_right,
    input  logic               round,
    input  logic               saturate_enable,
    output logic [Z_W-1:0]     z,
    output logic               out_valid,
    output logic               overflow
);

    localparam int PW = A_W + B_W + 2;

    if (!widths_ok(A_W, B_W, Z_W, ACC_W)) begin : g_bad_widths
        $error("rs_dsp_multacc_pipe: ACC_W must be >= A_W+B_W+2 and >= Z_W");
    end

    logic w_stall;
    logic w_adv;

`ifdef RS_DSP_MULTACC_STALL_EN
    assign w_stall = out_valid & ~out_ready;
`else
    assign w_stall = 1'b0;
`endif
    assign w_adv    = ~w_stall;
    assign in_ready = w_adv;

    ctrl_t w_ctl_in;
    assign w_ctl_in = '{unsigned_a, unsigned_b, feedback, load_acc, subtract,
                        shift_right, round, saturate_enable};

    // ---- S0: optional input register ----
    logic           w_vld_p0;
    logic [A_W-1:0] w_a_p0;
    logic [B_W-1:0] w_b_p0;
    ctrl_t          w_ctl_p0;

    if (IN_REG != 0) begin : g_in_reg
        logic           r_vld_p0;
        logic [A_W-1:0] r_a_p0;
        logic [B_W-1:0] r_b_p0;
        ctrl_t          r_ctl_p0;

        always_ff @(posedge clk or posedge lreset) begin
            if (lreset) begin
                r_vld_p0 <= 1'b0;
            end else if (w_adv) begin
                r_vld_p0 <= in_valid;
            end
        end

        always_ff @(posedge clk) begin
            if (w_adv) begin
                r_a_p0   <= a;
                r_b_p0   <= b;
                r_ctl_p0 <= w_ctl_in;
            end
        end

        assign w_vld_p0 = r_vld_p0;
        assign w_a_p0   = r_a_p0;
        assign w_b_p0   = r_b_p0;
        assign w_ctl_p0 = r_ctl_p0;
    end else begin : g_no_in_reg
        assign w_vld_p0 = in_valid;
        assign w_a_p0   = a;
        assign w_b_p0   = b;
        assign w_ctl_p0 = w_ctl_in;
    end

    // ---- S1: product register ----
    logic signed [A_W:0]       w_a_ext;
    logic signed [B_W:0]       w_b_ext;
    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_prod_sgn;

    assign w_a_ext    = {~w_ctl_p0.unsigned_a & w_a_p0[A_W-1], w_a_p0};
    assign w_b_ext    = {~w_ctl_p0.unsigned_b & w_b_p0[B_W-1], w_b_p0};
    assign w_prod     = PW'(w_a_ext) * PW'(w_b_ext);
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_prod_sgn = w_ctl_p0.subtract ? -w_prod_ext : w_prod_ext;

    logic                    r_vld_p1;
    logic signed [ACC_W-1:0] r_prod_p1;
    logic [1:0]              r_fb_p1;
    logic                    r_ld_p1;
    logic [SHIFT_W-1:0]      r_sh_p1;
    logic                    r_rnd_p1;
    logic                    r_sat_p1;
    logic                    r_uns_p1;

    always_ff @(posedge clk or posedge lreset) begin
        if (lreset) begin
            r_vld_p1 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p1 <= w_vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_prod_p1 <= w_prod_sgn;
            r_fb_p1   <= w_ctl_p0.feedback;
            r_ld_p1   <= w_ctl_p0.load_acc;
            r_sh_p1   <= w_ctl_p0.shift_right;
            r_rnd_p1  <= w_ctl_p0.round;
            r_sat_p1  <= w_ctl_p0.saturate_enable;
            r_uns_p1  <= w_ctl_p0.unsigned_a & w_ctl_p0.unsigned_b;
        end
    end

    // ---- S2: accumulate and output register ----
    logic signed [ACC_W-1:0] r_acc_p2;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [Z_W-1:0]          w_z;
    logic                    w_ovf;

    // The accumulator is read straight from its register, so MAC chains need no bubble.
    always_comb begin
        w_acc_next = r_prod_p1;
        case (r_fb_p1)
            FB_MAC:      w_acc_next = (r_ld_p1 ? '0 : r_acc_p2) + r_prod_p1;
            FB_READ_ACC: w_acc_next = r_acc_p2;
            default:     w_acc_next = r_prod_p1;
        endcase
    end

    rs_dsp_round_sat #(
        .ACC_W (ACC_W),
        .Z_W   (Z_W)
    ) u_round_sat (
        .i_value    (w_acc_next),
        .i_shift    (r_sh_p1),
        .i_round    (r_rnd_p1),
        .i_saturate (r_sat_p1),
        .i_unsigned (r_uns_p1),
        .o_z        (w_z),
        .o_overflow (w_ovf)
    );

    logic [Z_W-1:0] r_z_p2;
    logic           r_vld_p2;
    logic           r_ovf_p2;

    always_ff @(posedge clk or posedge lreset) begin
        if (lreset) begin
            r_acc_p2 <= '0;
            r_z_p2   <= '0;
            r_ovf_p2 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else if (w_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_acc_p2 <= w_acc_next;
                r_z_p2   <= w_z;
                r_ovf_p2 <= w_ovf;
            end
        end
    end

    assign z         = r_z_p2;
    assign out_valid = r_vld_p2;
    assign overflow  = r_ovf_p2;

endmodule

// File: tb/tb_rs_dsp_multacc_pipe.sv
// Scoreboard bench: a default instance (Z_W=38) and a Z_W=16 instance share stimulus.
module tb_rs_dsp_multacc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        lreset;
    logic        in_valid;
    logic [19:0] a;
    logic [17:0] b;
    logic        ua, ub, ld, sub, rnd, sat;
    logic [1:0]  fb;
    logic [5:0]  sh;
    logic        out_ready = 1'b1;

    logic        rdy38, rdy16, ov38, ov16, of38, of16;
    logic [37:0] z38;
    logic [15:0] z16;

    int errors = 0;
    int checks = 0;

    longint      m_acc;
    logic [37:0] q38_z[$];
    bit          q38_o[$];
    logic [15:0] q16_z[$];
    bit          q16_o[$];
    logic [37:0] last38, e38;
    logic [15:0] last16, e16;
    bit          eo;
    bit          stall_phase = 1'b0;

    rs_dsp_multacc_pipe u_dut38 (
        .clk(clk), .lreset(lreset), .in_valid(in_valid), .in_ready(rdy38),
`ifdef RS_DSP_MULTACC_STALL_EN
        .out_ready(out_ready),
`endif
        .a(a), .b(b), .unsigned_a(ua), .unsigned_b(ub), .feedback(fb),
        .load_acc(ld), .subtract(sub), .shift_right(sh), .round(rnd),
        .saturate_enable(sat), .z(z38), .out_valid(ov38), .overflow(of38)
    );

    rs_dsp_multacc_pipe #(.Z_W(16)) u_dut16 (
        .clk(clk), .lreset(lreset), .in_valid(in_valid), .in_ready(rdy16),
`ifdef RS_DSP_MULTACC_STALL_EN
        .out_ready(out_ready),
`endif
        .a(a), .b(b), .unsigned_a(ua), .unsigned_b(ub), .feedback(fb),
        .load_acc(ld), .subtract(sub), .shift_right(sh), .round(rnd),
        .saturate_enable(sat), .z(z16), .out_valid(ov16), .overflow(of16)
    );

    function automatic void chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Output rule from the specification, in plain 64-bit arithmetic.
    function automatic void out_model(input longint acc, input int s, input bit r, input bit st,
                                      input bit uns, input int zw, output longint zv, output bit o);
        longint v, hi, lo;
        if (s >= 48) v = (acc < 0) ? -1 : 0;
        else v = (acc + ((r && s > 0) ? (longint'(1) << (s - 1)) : 0)) >>> s;
        hi = uns ? (longint'(1) << zw) - 1 : (longint'(1) << (zw - 1)) - 1;
        lo = uns ? 0 : -(longint'(1) << (zw - 1));
        o  = (v > hi) || (v < lo);
        zv = (st && o) ? ((v > hi) ? hi : lo) : v;
    endfunction

    function automatic void push_model();
        longint va, vb, p, n, zv;
        logic signed [47:0] t;
        bit o;
        va = ua ? longint'(a) : longint'($signed(a));
        vb = ub ? longint'(b) : longint'($signed(b));
        p  = va * vb;
        if (sub) p = -p;
        case (fb)
            2'd1:    n = (ld ? 0 : m_acc) + p;
            2'd2:    n = m_acc;
            default: n = p;
        endcase
        t = n[47:0];
        n = t;
        m_acc = n;
        out_model(n, int'(sh), rnd, sat, ua && ub, 38, zv, o);
        q38_z.push_back(zv[37:0]);
        q38_o.push_back(o);
        out_model(n, int'(sh), rnd, sat, ua && ub, 16, zv, o);
        q16_z.push_back(zv[15:0]);
        q16_o.push_back(o);
    endfunction

    task automatic send(input int ia, input int ib, input int iua, input int iub, input int ifb,
                        input int ild, input int isub, input int ish, input int irnd, input int isat);
        bit ok = 1'b0;
        a = 20'(ia); b = 18'(ib); ua = 1'(iua); ub = 1'(iub); fb = 2'(ifb);
        ld = 1'(ild); sub = 1'(isub); sh = 6'(ish); rnd = 1'(irnd); sat = 1'(isat);
        in_valid = 1'b1;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (rdy38 && rdy16) begin
                ok = 1'b1;
                push_model();
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int n = 0; n < 60 && (q38_z.size() != 0 || q16_z.size() != 0); n++) @(posedge clk);
        #1;
        chk("drain38", q38_z.size(), 0);
        chk("drain16", q16_z.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!lreset) begin
            if (ov38 && out_ready) begin
                if (q38_z.size() == 0) chk("unexpected_out38", 1, 0);
                else begin
                    e38 = q38_z.pop_front(); eo = q38_o.pop_front();
                    chk("z38", longint'(z38), longint'(e38));
                    chk("ovf38", longint'(of38), longint'(eo));
                    last38 = e38;
                end
            end else if (!ov38) chk("hold38", longint'(z38), longint'(last38));
            if (ov16 && out_ready) begin
                if (q16_z.size() == 0) chk("unexpected_out16", 1, 0);
                else begin
                    e16 = q16_z.pop_front(); eo = q16_o.pop_front();
                    chk("z16", longint'(z16), longint'(e16));
                    chk("ovf16", longint'(of16), longint'(eo));
                    last16 = e16;
                end
            end else if (!ov16) chk("hold16", longint'(z16), longint'(last16));
`ifdef RS_DSP_MULTACC_STALL_EN
            if (ov38 && !out_ready) chk("in_ready_stall", longint'(rdy38), 0);
`endif
        end
    end

`ifdef RS_DSP_MULTACC_STALL_EN
    always @(posedge clk) begin
        #1;
        out_ready = stall_phase ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        lreset = 1'b1; in_valid = 1'b0; a = '0; b = '0; ua = 0; ub = 0; fb = '0;
        ld = 0; sub = 0; sh = '0; rnd = 0; sat = 0;
        m_acc = 0; last38 = '0; last16 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid38", longint'(ov38), 0);
        chk("rst_z38", longint'(z38), 0);
        chk("rst_ovf38", longint'(of38), 0);
        chk("rst_valid16", longint'(ov16), 0);
        chk("rst_z16", longint'(z16), 0);
        chk("rst_ovf16", longint'(of16), 0);
        lreset = 1'b0;
        @(posedge clk);
        #1;

        send(-3, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        send('hFFFFF, 2, 1, 1, 0, 0, 0, 0, 0, 0);
        send(1000, 1000, 0, 0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) send(1000, 1000, 0, 0, 1, 0, 0, 0, 0, 0);
        send(1000, 1000, 0, 0, 1, 0, 1, 0, 0, 0);
        send(0, 0, 0, 0, 2, 0, 0, 0, 0, 0);
        send(5, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        send(5, 1, 0, 0, 0, 0, 0, 1, 0, 0);
        send(-5, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        send(300, 300, 0, 0, 0, 0, 0, 0, 0, 1);
        send(300, 300, 0, 0, 0, 0, 0, 0, 0, 0);
        send(300, 300, 1, 1, 0, 0, 1, 0, 0, 1);
        send(-300, 300, 0, 1, 0, 0, 0, 0, 0, 1);
        send(-7, 3, 0, 0, 3, 0, 0, 50, 1, 0);
        drain();

        send(7, 9, 0, 0, 0, 0, 0, 0, 0, 0);
        send(11, 13, 0, 0, 1, 0, 0, 0, 0, 0);
        in_valid = 1'b0;
        #1;
        lreset = 1'b1;
        #1;
        chk("midrst_valid38", longint'(ov38), 0);
        chk("midrst_z38", longint'(z38), 0);
        chk("midrst_ovf38", longint'(of38), 0);
        chk("midrst_z16", longint'(z16), 0);
        q38_z.delete(); q38_o.delete(); q16_z.delete(); q16_o.delete();
        m_acc = 0; last38 = '0; last16 = '0;
        @(posedge clk);
        #1;
        lreset = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        stall_phase = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(int'($urandom), int'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 63)) : int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
            if ($urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        stall_phase = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
